// File: rtl/cam_seq_pkg.sv
// Shared types and constants for the camera command sequencer:
// FSM state encoding, table markers and the per-profile command tables.
package cam_seq_pkg;

    localparam int CMD_W = 16;

    localparam logic [CMD_W-1:0] END_MARK  = 16'hFFFF;
    localparam logic [7:0]       DELAY_TAG = 8'hFE;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        PRESENT,
        DELAY,
        DONE
    } seq_state_t;

    // Stored length of each built-in table; entries past this read as END_MARK.
    localparam int TABLE_LEN  = 8;
    localparam int NUM_TABLES = 2;

    typedef logic [CMD_W-1:0] table_t [NUM_TABLES][TABLE_LEN];

    // Entry format: {register address, value}; 16'hFExx waits xx delay ticks.
    localparam table_t PROFILE_TABLES = '{
        '{16'h1280, 16'h1280, 16'h1200, 16'h3011,
          16'h3022, 16'hFFFF, 16'hFFFF, 16'hFFFF},
        '{16'h2101, 16'hFE02, 16'h2102, 16'hFE00,
          16'h2103, 16'hFFFF, 16'hFFFF, 16'hFFFF}
    };

endpackage

// File: rtl/cam_cmd_rom.sv
// Command table storage: one flat array addressed by {profile, index},
// with a registered read port so it maps onto block RAM.
module cam_cmd_rom
    import cam_seq_pkg::*;
#(
    parameter int NUM_PROFILES = 2,
    parameter int DEPTH        = 64,
    parameter int PROF_W       = 1,
    parameter int IDX_W        = 6
) (
    input  logic              clk,
    input  logic [PROF_W-1:0] profile,
    input  logic [IDX_W-1:0]  index,
    output logic [CMD_W-1:0]  entry
);

    localparam int ADDR_W   = PROF_W + IDX_W;
    localparam int ROM_SIZE = 2 ** ADDR_W;

    logic [CMD_W-1:0]  rom_mem [ROM_SIZE];
    logic [ADDR_W-1:0] addr;

    assign addr = {profile, index};

    // Unused profiles and slots beyond the stored tables read as the end marker.
    genvar gi;
    generate
        for (gi = 0; gi < ROM_SIZE; gi++) begin : g_fill
            localparam int PROF = gi / (2 ** IDX_W);
            localparam int IDX  = gi % (2 ** IDX_W);
            if (PROF < NUM_PROFILES && PROF < NUM_TABLES &&
                IDX < TABLE_LEN && IDX < DEPTH) begin : g_tab
                assign rom_mem[gi] = PROFILE_TABLES[PROF][IDX];
            end else begin : g_pad
                assign rom_mem[gi] = END_MARK;
            end
        end
    endgenerate

    // Registered read: entry reflects the address presented on the previous edge.
    always_ff @(posedge clk) begin
        entry <= rom_mem[addr];
    end

endmodule

// File: rtl/cam_cmd_sequencer.sv
// Plays a selected command table out to a register-write consumer, one
// entry per advance handshake, with embedded millisecond-style delays.
module cam_cmd_sequencer
    import cam_seq_pkg::*;
#(
    parameter int NUM_PROFILES = 2,
    parameter int DEPTH        = 64,
    parameter int DELAY_UNIT   = 100000,
    parameter int AUTO_START   = 1,
    localparam int PROF_W      = (NUM_PROFILES > 1) ? $clog2(NUM_PROFILES) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [PROF_W-1:0] profile_sel,
    input  logic              advance,
    output logic [CMD_W-1:0]  command,
    output logic              cmd_valid,
    output logic              busy,
    output logic              finished
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(255 * DELAY_UNIT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    seq_state_t        state_reg, state_next;
    logic [IDX_W-1:0]  index_reg, index_next;
    logic [PROF_W-1:0] profile_reg, profile_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic [CMD_W-1:0]  rom_data;

    // The ROM is addressed with the next-state pointer, so rom_data always
    // holds entry[profile_reg][index_reg] and FETCH can decode in one cycle.
    cam_cmd_rom #(
        .NUM_PROFILES (NUM_PROFILES),
        .DEPTH        (DEPTH),
        .PROF_W       (PROF_W),
        .IDX_W        (IDX_W)
    ) u_rom (
        .clk     (clk),
        .profile (profile_next),
        .index   (index_next),
        .entry   (rom_data)
    );

    // State, pointer and delay counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            index_reg   <= '0;
            profile_reg <= '0;
            count_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            index_reg   <= index_next;
            profile_reg <= profile_next;
            count_reg   <= count_next;
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_next   = state_reg;
        index_next   = index_reg;
        profile_next = profile_reg;
        count_next   = count_reg;
        command      = END_MARK;
        cmd_valid    = 1'b0;
        busy         = 1'b0;
        finished     = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    profile_next = profile_sel;
                    index_next   = '0;
                    count_next   = '0;
                    state_next   = FETCH;
                end else if (AUTO_START != 0) begin
                    profile_next = '0;
                    index_next   = '0;
                    count_next   = '0;
                    state_next   = FETCH;
                end
            end

            FETCH: begin
                busy = 1'b1;
                if (rom_data == END_MARK) begin
                    state_next = DONE;
                end else if (rom_data[15:8] == DELAY_TAG) begin
                    count_next = CNT_W'(rom_data[7:0]) * CNT_W'(DELAY_UNIT);
                    state_next = DELAY;
                end else begin
                    state_next = PRESENT;
                end
            end

            PRESENT: begin
                busy      = 1'b1;
                command   = rom_data;
                cmd_valid = 1'b1;
                if (advance) begin
                    // Running off the end of the table finishes; no wrap.
                    if (index_reg == LAST_IDX) begin
                        state_next = DONE;
                    end else begin
                        index_next = index_reg + 1'b1;
                        state_next = FETCH;
                    end
                end
            end

            DELAY: begin
                busy = 1'b1;
                if (count_reg == '0) begin
                    if (index_reg == LAST_IDX) begin
                        state_next = DONE;
                    end else begin
                        index_next = index_reg + 1'b1;
                        state_next = FETCH;
                    end
                end else begin
                    count_next = count_reg - 1'b1;
                end
            end

            DONE: begin
                finished = 1'b1;
                if (start) begin
                    profile_next = profile_sel;
                    index_next   = '0;
                    count_next   = '0;
                    state_next   = FETCH;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cam_cmd_sequencer.sv
// Directed bench for cam_cmd_sequencer: a full-depth instance runs both
// profiles with delays, holds, ignored starts/advances and a mid-delay
// reset; a DEPTH=4 instance checks end-of-table without an end marker.
module tb_cam_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst_n, start, profile_sel, advance;
    logic [15:0] command;
    logic        cmd_valid, busy, finished;

    logic        rst4_n, start4, profile_sel4, advance4;
    logic [15:0] command4;
    logic        cmd_valid4, busy4, finished4;

    int check_count = 0;
    int error_count = 0;

    always #5 clk = ~clk;

    cam_cmd_sequencer #(
        .NUM_PROFILES (2),
        .DEPTH        (64),
        .DELAY_UNIT   (10),
        .AUTO_START   (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .profile_sel (profile_sel),
        .advance     (advance),
        .command     (command),
        .cmd_valid   (cmd_valid),
        .busy        (busy),
        .finished    (finished)
    );

    cam_cmd_sequencer #(
        .NUM_PROFILES (2),
        .DEPTH        (4),
        .DELAY_UNIT   (10),
        .AUTO_START   (1)
    ) dut4 (
        .clk         (clk),
        .rst_n       (rst4_n),
        .start       (start4),
        .profile_sel (profile_sel4),
        .advance     (advance4),
        .command     (command4),
        .cmd_valid   (cmd_valid4),
        .busy        (busy4),
        .finished    (finished4)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got !== exp) begin
            error_count++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Wait (bounded) for cmd_valid, counting low cycles; optionally pulse
    // advance while nothing is presented, which must have no effect.
    task automatic wait_cmd(input string tag, input logic [15:0] exp, input int adv_at,
                            output int gap);
        gap = 0;
        while (cmd_valid !== 1'b1 && gap < 400) begin
            advance = (gap == adv_at);
            @(negedge clk);
            gap++;
        end
        advance = 1'b0;
        check_val({tag, "_valid"}, 32'(cmd_valid), 32'd1);
        check_val({tag, "_cmd"}, 32'(command), 32'(exp));
        $display("txn %s: command=%h after %0d idle cycles", tag, command, gap);
    endtask

    task automatic accept();
        advance = 1'b1;
        @(negedge clk);
        advance = 1'b0;
    endtask

    task automatic wait_finished(input string tag, input int exp_cycles);
        int n;
        n = 0;
        while (finished !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_val({tag, "_latency"}, 32'(n), 32'(exp_cycles));
        check_val({tag, "_outputs"}, {13'd0, command, cmd_valid, busy, finished},
                  {13'd0, 16'hFFFF, 3'b001});
        $display("txn %s: finished after %0d cycles", tag, n);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int gap;
        int bad;
        int n;
        int cnt;
        logic [15:0] exp4 [4];

        exp4 = '{16'h1280, 16'h1280, 16'h1200, 16'h3011};

        rst_n = 1'b0; start = 1'b0; profile_sel = 1'b0; advance = 1'b0;
        rst4_n = 1'b0; start4 = 1'b0; profile_sel4 = 1'b0; advance4 = 1'b0;

        repeat (3) @(negedge clk);
        check_val("reset_outputs", {13'd0, command, cmd_valid, busy, finished},
                  {13'd0, 16'hFFFF, 3'b000});

        // Auto start: FETCH on the first edge, first command one cycle later.
        rst_n = 1'b1;
        @(negedge clk);
        check_val("auto_start_fetch", {29'd0, busy, cmd_valid, finished}, 32'b100);
        wait_cmd("p0_e0", 16'h1280, -1, gap);
        check_val("p0_e0_gap", 32'(gap), 32'd1);

        // Hold without advance for 50 cycles; a start for profile 1 is ignored.
        bad = 0;
        profile_sel = 1'b1;
        for (int i = 0; i < 50; i++) begin
            start = (i == 20);
            @(negedge clk);
            if (command !== 16'h1280 || cmd_valid !== 1'b1 || busy !== 1'b1) bad++;
        end
        start = 1'b0;
        profile_sel = 1'b0;
        check_val("hold_stable", 32'(bad), 32'd0);

        // Rest of profile 0 in table order; each new command two edges after advance.
        accept();
        wait_cmd("p0_e1", 16'h1280, -1, gap);
        check_val("p0_e1_gap", 32'(gap), 32'd1);
        accept();
        wait_cmd("p0_e2", 16'h1200, -1, gap);
        accept();
        wait_cmd("p0_e3", 16'h3011, -1, gap);
        accept();
        wait_cmd("p0_e4", 16'h3022, -1, gap);
        accept();
        wait_finished("p0_done", 1);

        // Advance in DONE changes nothing.
        accept();
        check_val("done_ignores_advance", {29'd0, finished, cmd_valid, busy}, 32'b100);

        // Restart with profile 1; finished drops on the next cycle.
        profile_sel = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_val("restart_finished_drop", {30'd0, finished, busy}, 32'b01);
        wait_cmd("p1_e0", 16'h2101, -1, gap);
        check_val("p1_e0_gap", 32'(gap), 32'd1);

        // FE02 at DELAY_UNIT=10: 21 delay cycles (20 down to 0) plus one
        // fetch of the marker and one fetch of the next entry.
        accept();
        wait_cmd("p1_e2", 16'h2102, 10, gap);
        check_val("p1_delay2_gap", 32'(gap), 32'd23);

        // FE00: a single delay cycle between the two fetches.
        accept();
        wait_cmd("p1_e4", 16'h2103, -1, gap);
        check_val("p1_delay0_gap", 32'(gap), 32'd3);
        accept();
        wait_finished("p1_done", 1);

        // Reset in the middle of a delay.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_cmd("p1b_e0", 16'h2101, -1, gap);
        accept();
        repeat (6) @(negedge clk);
        check_val("in_delay", {30'd0, busy, cmd_valid}, 32'b10);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_reset_outputs", {13'd0, command, cmd_valid, busy, finished},
                  {13'd0, 16'hFFFF, 3'b000});
        @(negedge clk);
        check_val("reset_held_outputs", {13'd0, command, cmd_valid, busy, finished},
                  {13'd0, 16'hFFFF, 3'b000});
        rst_n = 1'b1;
        @(negedge clk);
        wait_cmd("rst_e0", 16'h1280, -1, gap);
        check_val("rst_e0_gap", 32'(gap), 32'd1);
        accept();
        wait_cmd("rst_e1", 16'h1280, -1, gap);
        accept();
        wait_cmd("rst_e2", 16'h1200, -1, gap);

        // DEPTH=4 instance: four commands, then finished without wrapping.
        rst4_n = 1'b1;
        n = 0;
        cnt = 0;
        while (finished4 !== 1'b1 && n < 200) begin
            advance4 = 1'b0;
            if (cmd_valid4 === 1'b1) begin
                if (cnt < 4) check_val("d4_cmd", 32'(command4), 32'(exp4[cnt]));
                $display("txn d4_e%0d: command=%h", cnt, command4);
                cnt++;
                advance4 = 1'b1;
            end
            @(negedge clk);
            n++;
        end
        advance4 = 1'b0;
        check_val("d4_count", 32'(cnt), 32'd4);
        check_val("d4_finished", {31'd0, finished4}, 32'd1);
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (cmd_valid4 !== 1'b0 || finished4 !== 1'b1 || command4 !== 16'hFFFF) bad++;
        end
        check_val("d4_no_wrap", 32'(bad), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule

// File: doc/cam_cmd_sequencer.md
CAM_CMD_SEQUENCER -- requirements
Module: cam_cmd_sequencer

Interface
REQ-001 SHALL have parameter NUM_PROFILES, default 2: number of independent command tables.
REQ-002 SHALL have parameter DEPTH, default 64: entries per profile table.
REQ-003 SHALL have parameter DELAY_UNIT, default 100000: clock cycles per delay tick (1 ms at 100 MHz).
REQ-004 SHALL have parameter AUTO_START, default 1: if 1, the block starts profile 0 on reset release.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port start, input, 1 bit: single-cycle request to run the selected profile.
REQ-008 SHALL have port profile_sel, input, $clog2(NUM_PROFILES) bits: table selector.
REQ-009 SHALL have port advance, input, 1 bit: consumer accepts the current command.
REQ-010 SHALL have port command, output, 16 bits: {register address[15:8], value[7:0]}.
REQ-011 SHALL have port cmd_valid, output, 1 bit: command is presentable.
REQ-012 SHALL have port busy, output, 1 bit: a sequence is in progress.
REQ-013 SHALL have port finished, output, 1 bit: last sequence completed.

Function
REQ-014 SHALL implement an FSM with states IDLE, FETCH, PRESENT, DELAY and DONE.
REQ-015 SHALL, in IDLE or DONE, on start=1, latch profile_sel, clear index to 0, clear finished, and enter FETCH.
REQ-016 SHALL ignore start in FETCH, PRESENT and DELAY; profile_sel is sampled only at the accepted start.
REQ-017 SHALL read the table with one-cycle latency: FETCH registers entry[profile][index], then moves to decode on the next cycle.
REQ-018 SHALL decode the entry as follows:
- 16'hFFFF (end marker): go to DONE.
- high byte 8'hFE (delay marker): go to DELAY and load the counter with low byte * DELAY_UNIT.
- otherwise: go to PRESENT.
REQ-019 SHALL, in PRESENT, drive command=entry and cmd_valid=1.
REQ-020 SHALL, in PRESENT with advance=1, increment index and return to FETCH; the next cmd_valid therefore rises no sooner than 2 cycles after advance.
REQ-021 SHALL ignore advance whenever cmd_valid=0.
REQ-022 SHALL, in DELAY, decrement the counter each cycle and, after it reaches 0, increment index and enter FETCH.
REQ-023 SHALL treat a delay value of 0 as zero wait: 1 cycle in DELAY.
REQ-024 SHALL size the delay counter to hold 255*DELAY_UNIT without overflow.
REQ-025 SHALL treat index reaching DEPTH with no end marker as end of sequence: DONE, no wrap to 0.
REQ-026 SHALL hold command=16'hFFFF and cmd_valid=0 in IDLE, FETCH, DELAY and DONE.
REQ-027 SHALL set busy=1 in FETCH, PRESENT and DELAY, and busy=0 otherwise.
REQ-028 SHALL set finished=1 in DONE only.
REQ-029 SHALL leave DONE only on start, which restarts the sequence.
REQ-030 SHALL make the start/end state transitions (accepted start, end of sequence) mutually exclusive with an advance in the same cycle; an advance in a non-PRESENT state has no effect.

Reset
REQ-031 SHALL, on rst_n=0, asynchronously force state=IDLE, index=0, profile=0, counter=0, command=16'hFFFF, cmd_valid=0, busy=0, finished=0.
REQ-032 SHALL abort any sequence in progress on reset, with no partial command left presented.
REQ-033 SHALL, with AUTO_START=1, enter FETCH for profile 0 on the first clock after rst_n deasserts.

Structure
REQ-034 SHALL define in shared package cam_seq_pkg:
- the state enum type;
- constants END_MARK=16'hFFFF, DELAY_TAG=8'hFE, CMD_W=16;
- profile table contents as constant arrays.
REQ-035 SHALL contain one sub-module, cam_cmd_rom: registered-output table lookup indexed by {profile, index}.

Verification
REQ-036 SHALL cover: reset release with AUTO_START=1 and advance pulsed each time cmd_valid rises -> profile 0 commands emitted in table order, starting 16'h1280, 16'h1280, 16'h1200; finished=1 after the end marker.
REQ-037 SHALL cover: profile 1 table containing 16'hFE02 with DELAY_UNIT=10 -> cmd_valid low for exactly 21 cycles between the preceding advance+fetch and the next presented command.
REQ-038 SHALL cover: advance held 0 for 50 cycles in PRESENT -> command stable, index unchanged; advance pulsed in IDLE/DELAY -> no index change.
REQ-039 SHALL cover: start with profile_sel=1 while busy -> ignored; start after finished -> profile 1 runs from index 0 and finished drops the next cycle.
REQ-040 SHALL cover: table of DEPTH=4 with no end marker -> exactly 4 commands presented, then finished=1 with no wrap.
REQ-041 SHALL cover: rst_n asserted mid-DELAY -> all outputs at reset values asynchronously; sequence restarts from index 0.
